// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
// Default geometry, element typedefs and row-major packing helpers.
package systolic_pkg;

   localparam int DEF_ROWS      = 2;
   localparam int DEF_COLS      = 2;
   localparam int DEF_ACC_WIDTH = 9;
   localparam int DEF_OUT_WIDTH = 8;
   localparam int DEF_SHIFT     = 0;
   localparam int DEF_CNT_WIDTH = 8;
   localparam int NUM_ELEM      = DEF_ROWS * DEF_COLS;

   typedef logic [DEF_ACC_WIDTH-1:0]          elem_t;
   typedef logic [DEF_OUT_WIDTH-1:0]          out_elem_t;
   typedef logic [NUM_ELEM*DEF_ACC_WIDTH-1:0] mat_t;

   // Index width for a count of n items; a single item still needs one bit.
   function automatic int IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Element k = r*COLS + c of a row-major packed matrix.
   function automatic elem_t elem_slice(input mat_t m, input int k);
      return m[k*DEF_ACC_WIDTH +: DEF_ACC_WIDTH];
   endfunction

endpackage

// File: rtl/systolic_requant.sv
// Requantizes one accumulator element: logical right shift, then unsigned
// saturation to the output width.
module systolic_requant #(
   parameter int ACC_WIDTH = 9,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 0
) (
   input  logic [ACC_WIDTH-1:0] elem,
   output logic [OUT_WIDTH-1:0] q
);

   logic [ACC_WIDTH-1:0] shifted;

   assign shifted = elem >> SHIFT;

   // A wide enough output can hold every shifted value, so no clamp is built.
   if (OUT_WIDTH >= ACC_WIDTH) begin : g_nosat
      assign q = OUT_WIDTH'(shifted);
   end else begin : g_sat
      assign q = (|shifted[ACC_WIDTH-1:OUT_WIDTH]) ? '1 : shifted[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/systolic_drain.sv
// Captures completed C matrices into a 2-slot ping-pong buffer and streams
// them row-major on a valid/ready port, requantizing each element.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mat_valid,
   input  logic [ROWS*COLS*ACC_WIDTH-1:0] mat_c,
   output logic                           slot_free,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_WIDTH-1:0]           out_data,
   output logic [IDX_W(ROWS)-1:0]         out_row,
   output logic [IDX_W(COLS)-1:0]         out_col,
   output logic                           out_last,
   output logic                           overflow,
   output logic [CNT_WIDTH-1:0]           drop_count,
   input  logic                           clear_ovf
);

   localparam int NUM   = ROWS * COLS;
   localparam int EW    = IDX_W(NUM);
   localparam int RW    = IDX_W(ROWS);
   localparam int CW    = IDX_W(COLS);
   localparam int MAT_W = NUM * ACC_WIDTH;
   localparam logic [EW-1:0] LAST_IDX = EW'(NUM - 1);

   logic [MAT_W-1:0]     slot_mem [2];
   logic [1:0]           full;
   logic [1:0]           full_nxt;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [EW-1:0]        elem_idx;
   logic                 handshake;
   logic                 release_rd;
   logic                 capture;
   logic                 drop;
   logic [ACC_WIDTH-1:0] sel_elem;

   // A full buffer can still accept when the slot under wr_ptr is being
   // released on this very edge (wr_ptr == rd_ptr whenever both are full).
   always_comb begin
      handshake  = full[rd_ptr] & out_ready;
      release_rd = handshake & (elem_idx == LAST_IDX);
      capture    = mat_valid & (~full[wr_ptr] | (release_rd & (wr_ptr == rd_ptr)));
      drop       = mat_valid & ~capture;
      full_nxt   = full;
      if (release_rd) full_nxt[rd_ptr] = 1'b0;
      if (capture)    full_nxt[wr_ptr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full        <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         elem_idx    <= '0;
         slot_mem[0] <= '0;
         slot_mem[1] <= '0;
      end else begin
         full <= full_nxt;
         if (handshake) elem_idx <= release_rd ? '0 : elem_idx + 1'b1;
         if (release_rd) rd_ptr <= ~rd_ptr;
         if (capture) begin
            slot_mem[wr_ptr] <= mat_c;
            wr_ptr           <= ~wr_ptr;
         end
      end
   end

   // A drop coinciding with clear_ovf leaves exactly that one drop recorded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_ovf)           drop_count <= CNT_WIDTH'(1);
         else if (~&drop_count)   drop_count <= drop_count + 1'b1;
      end else if (clear_ovf) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

   always_comb begin
      out_valid = full[rd_ptr];
      slot_free = ~(full[0] & full[1]);
      out_last  = (elem_idx == LAST_IDX);
      out_row   = RW'(int'(elem_idx) / COLS);
      out_col   = CW'(int'(elem_idx) % COLS);
      sel_elem  = slot_mem[rd_ptr][int'(elem_idx)*ACC_WIDTH +: ACC_WIDTH];
   end

   systolic_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_requant (
      .elem (sel_elem),
      .q    (out_data)
   );

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: two instances (SHIFT 0 and 1) share stimulus and are
// compared every cycle against a queue-level model plus literal expectations.
module tb_systolic_drain;
   import systolic_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       mat_valid;
   mat_t       mat_c;
   logic       out_ready;
   logic       clear_ovf;

   logic       slot_free0, out_valid0, out_last0, overflow0;
   out_elem_t  out_data0;
   logic [0:0] out_row0, out_col0;
   logic [7:0] drop_count0;
   logic       slot_free1, out_valid1, out_last1, overflow1;
   out_elem_t  out_data1;
   logic [0:0] out_row1, out_col1;
   logic [7:0] drop_count1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sf_zero = 0;

   typedef struct {
      int cyc;
      int d0;
      int d1;
      int row;
      int col;
      int last;
   } entry_t;
   entry_t log_q[$];

   mat_t pend[$];
   int   pos = 0;
   int   m_ovf = 0;
   int   m_cnt = 0;

   int ROW_E[4]  = '{0, 0, 1, 1};
   int COL_E[4]  = '{0, 1, 0, 1};
   int LAST_E[4] = '{0, 0, 0, 1};

   systolic_drain #(.SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .mat_valid(mat_valid), .mat_c(mat_c),
      .slot_free(slot_free0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_row(out_row0), .out_col(out_col0),
      .out_last(out_last0), .overflow(overflow0), .drop_count(drop_count0),
      .clear_ovf(clear_ovf)
   );

   systolic_drain #(.SHIFT(1)) dut1 (
      .clk(clk), .rst(rst), .mat_valid(mat_valid), .mat_c(mat_c),
      .slot_free(slot_free1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_row(out_row1), .out_col(out_col1),
      .out_last(out_last1), .overflow(overflow1), .drop_count(drop_count1),
      .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic mat_t pack4(input int a, input int b, input int c, input int d);
      return {elem_t'(d), elem_t'(c), elem_t'(b), elem_t'(a)};
   endfunction

   function automatic int req(input int e, input int sh);
      int v;
      v = e >> sh;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: a FIFO of whole matrices holding at most two, read one element at a time.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend.delete();
         pos   = 0;
         m_ovf = 0;
         m_cnt = 0;
      end else begin
         bit hs, fin, take;
         hs   = (pend.size() > 0) && out_ready;
         fin  = hs && (pos == NUM_ELEM - 1);
         take = mat_valid && ((pend.size() < 2) || fin);
         if (hs) pos++;
         if (fin) begin
            void'(pend.pop_front());
            pos = 0;
         end
         if (take) pend.push_back(mat_c);
         else if (mat_valid) begin
            m_ovf = 1;
            m_cnt = clear_ovf ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clear_ovf) begin
            m_ovf = 0;
            m_cnt = 0;
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of accepted elements.
   always @(negedge clk) begin
      check_output("out_valid0", int'(out_valid0), int'(pend.size() > 0));
      check_output("out_valid1", int'(out_valid1), int'(pend.size() > 0));
      check_output("slot_free", int'(slot_free0), int'(pend.size() < 2));
      check_output("overflow", int'(overflow0), m_ovf);
      check_output("drop_count", int'(drop_count0), m_cnt);
      check_output("drop_count1", int'(drop_count1), m_cnt);
      if (pend.size() > 0) begin
         int e;
         e = int'(elem_slice(pend[0], pos));
         check_output("out_data0", int'(out_data0), req(e, 0));
         check_output("out_data1", int'(out_data1), req(e, 1));
         check_output("out_row", int'(out_row0), pos / DEF_COLS);
         check_output("out_col", int'(out_col0), pos % DEF_COLS);
         check_output("out_last", int'(out_last0), int'(pos == NUM_ELEM - 1));
      end
      if (!slot_free0) sf_zero++;
      if (out_valid0 && out_ready)
         log_q.push_back('{cyc, int'(out_data0), int'(out_data1),
                           int'(out_row0), int'(out_col0), int'(out_last0)});
   end

   task automatic apply_stimulus(input logic mv, input mat_t m, input logic rdy, input logic clr);
      mat_valid = mv;
      mat_c     = m;
      out_ready = rdy;
      clear_ovf = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) apply_stimulus(1'b0, '0, rdy, 1'b0);
   endtask

   task automatic check_entry(input string tag, input int i, input int d0, input int d1,
                              input int row, input int col, input int last);
      if (i >= log_q.size()) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: entry %0d missing, got %0d entries", tag, i, log_q.size());
      end else begin
         check_output({tag, "_d0"}, log_q[i].d0, d0);
         check_output({tag, "_d1"}, log_q[i].d1, d1);
         check_output({tag, "_row"}, log_q[i].row, row);
         check_output({tag, "_col"}, log_q[i].col, col);
         check_output({tag, "_last"}, log_q[i].last, last);
      end
   endtask

   task automatic check_matrix(input string tag, input int start, input int d0[4], input int d1[4]);
      for (int k = 0; k < 4; k++)
         check_entry(tag, start + k, d0[k], d1[k], ROW_E[k], COL_E[k], LAST_E[k]);
   endtask

   initial begin
      int base;
      int sfb;
      rst       = 1'b0;
      mat_valid = 1'b0;
      mat_c     = '0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_out_valid", int'(out_valid0), 0);
      check_output("rst_out_last", int'(out_last0), 0);
      check_output("rst_out_row", int'(out_row0), 0);
      check_output("rst_out_col", int'(out_col0), 0);
      check_output("rst_out_data", int'(out_data0), 0);
      check_output("rst_overflow", int'(overflow0), 0);
      check_output("rst_drop_count", int'(drop_count0), 0);
      check_output("rst_slot_free", int'(slot_free0), 1);
      rst = 1'b0;
      idle(1, 1'b1);

      $display("[TB] single matrix");
      base = log_q.size();
      check_output("t1_idle_valid", int'(out_valid0), 0);
      apply_stimulus(1'b1, pack4(10, 20, 30, 40), 1'b1, 1'b0);
      check_output("t1_latency", int'(out_valid0), 1);
      idle(5, 1'b1);
      check_output("t1_count", log_q.size() - base, 4);
      check_matrix("t1", base, '{10, 20, 30, 40}, '{5, 10, 15, 20});
      check_output("t1_gap", log_q[base+3].cyc - log_q[base].cyc, 3);

      $display("[TB] saturation and shift");
      base = log_q.size();
      apply_stimulus(1'b1, pack4(450, 256, 255, 0), 1'b1, 1'b0);
      idle(5, 1'b1);
      check_output("t2_count", log_q.size() - base, 4);
      check_matrix("t2", base, '{255, 255, 255, 0}, '{225, 128, 127, 0});

      $display("[TB] backpressure");
      base = log_q.size();
      apply_stimulus(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         apply_stimulus(1'b0, '0, ((i % 4) == 0) || ((i % 4) == 3), 1'b0);
      check_output("t3_count", log_q.size() - base, 4);
      check_matrix("t3", base, '{1, 2, 3, 4}, '{0, 1, 1, 2});

      $display("[TB] ping-pong");
      base = log_q.size();
      sfb  = sf_zero;
      apply_stimulus(1'b1, pack4(1, 2, 3, 4), 1'b1, 1'b0);
      idle(1, 1'b1);
      apply_stimulus(1'b1, pack4(5, 6, 7, 8), 1'b1, 1'b0);
      idle(8, 1'b1);
      check_output("t4_count", log_q.size() - base, 8);
      check_matrix("t4a", base, '{1, 2, 3, 4}, '{0, 1, 1, 2});
      check_matrix("t4b", base + 4, '{5, 6, 7, 8}, '{2, 3, 3, 4});
      if (log_q.size() - base >= 8)
         check_output("t4_no_bubble", log_q[base+7].cyc - log_q[base].cyc, 7);
      check_output("t4_slot_full_cycles", sf_zero - sfb, 2);

      $display("[TB] overrun");
      base = log_q.size();
      apply_stimulus(1'b1, pack4(11, 12, 13, 14), 1'b0, 1'b0);
      idle(1, 1'b0);
      apply_stimulus(1'b1, pack4(21, 22, 23, 24), 1'b0, 1'b0);
      idle(1, 1'b0);
      apply_stimulus(1'b1, pack4(31, 32, 33, 34), 1'b0, 1'b0);
      idle(1, 1'b0);
      check_output("t5_ovf", int'(overflow0), 1);
      check_output("t5_cnt", int'(drop_count0), 1);
      check_output("t5_slot_free", int'(slot_free0), 0);
      apply_stimulus(1'b1, pack4(31, 32, 33, 34), 1'b0, 1'b0);
      check_output("t5_cnt2", int'(drop_count0), 2);
      apply_stimulus(1'b1, pack4(31, 32, 33, 34), 1'b0, 1'b1);
      check_output("t5_dropwins_ovf", int'(overflow0), 1);
      check_output("t5_dropwins_cnt", int'(drop_count0), 1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("t5_clear_ovf", int'(overflow0), 0);
      check_output("t5_clear_cnt", int'(drop_count0), 0);
      repeat (257) apply_stimulus(1'b1, pack4(31, 32, 33, 34), 1'b0, 1'b0);
      check_output("t5_sat_cnt", int'(drop_count0), 255);
      check_output("t5_sat_ovf", int'(overflow0), 1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("t5_clear2_cnt", int'(drop_count0), 0);
      idle(3, 1'b1);
      apply_stimulus(1'b1, pack4(41, 42, 43, 44), 1'b1, 1'b0);
      check_output("t5_coinc_cnt", int'(drop_count0), 0);
      check_output("t5_coinc_ovf", int'(overflow0), 0);
      check_output("t5_coinc_full", int'(slot_free0), 0);
      idle(10, 1'b1);
      check_output("t5_count", log_q.size() - base, 12);
      check_matrix("t5a", base, '{11, 12, 13, 14}, '{5, 6, 6, 7});
      check_matrix("t5b", base + 4, '{21, 22, 23, 24}, '{10, 11, 11, 12});
      check_matrix("t5c", base + 8, '{41, 42, 43, 44}, '{20, 21, 21, 22});

      $display("[TB] reset mid-stream");
      base = log_q.size();
      apply_stimulus(1'b1, pack4(5, 6, 7, 8), 1'b1, 1'b0);
      idle(2, 1'b1);
      rst = 1'b1;
      #1;
      check_output("t6_async_valid", int'(out_valid0), 0);
      check_output("t6_slot_free", int'(slot_free0), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1, 1'b1);
      check_output("t6_post_slot_free", int'(slot_free0), 1);
      apply_stimulus(1'b1, pack4(9, 10, 11, 12), 1'b1, 1'b0);
      idle(5, 1'b1);
      check_output("t6_count", log_q.size() - base, 6);
      check_entry("t6_pre0", base, 5, 2, 0, 0, 0);
      check_entry("t6_pre1", base + 1, 6, 3, 0, 1, 0);
      check_matrix("t6", base + 2, '{9, 10, 11, 12}, '{4, 5, 5, 6});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
